logistic_mu_sweep: RTL and testbench

//  Upstream control stage for logisticModule: owns mu and maxrepeat, and drives the map's active-low RST.

---
 rtl/logistic_mu_sweep_if.sv | 22 ++
 rtl/logistic_mu_sweep.sv | 197 +++++++++++++++++++
 tb/tb_logistic_mu_sweep.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/logistic_mu_sweep_if.sv
// Bundle between the mu sweep controller and its surroundings: front-panel inputs
// plus the mu/maxrepeat/restart signals that feed logisticModule.
interface logistic_mu_sweep_if;
    logic        frame_tick;
    logic        auto_en;
    logic        btn_up;
    logic        btn_down;
    logic [17:0] mu;
    logic [8:0]  maxrepeat;
    logic        cycle_rst_n;
    logic        settled;

    modport master (
        input  frame_tick, auto_en, btn_up, btn_down,
        output mu, maxrepeat, cycle_rst_n, settled
    );

    modport slave (
        output frame_tick, auto_en, btn_up, btn_down,
        input  mu, maxrepeat, cycle_rst_n, settled
    );
endinterface

// File: rtl/logistic_mu_sweep.sv
// Owns mu for logisticModule: restarts the iterators on every mu change, waits for them
// to settle, then holds mu until an auto frame count or a debounced button asks for a step.
module logistic_mu_sweep #(
    parameter logic [17:0] MU_MIN          = 18'h2_8000,
    parameter logic [17:0] MU_MAX          = 18'h3_FFF0,
    parameter logic [17:0] MU_STEP         = 18'h0_0400,
    parameter logic [8:0]  REPEAT          = 9'd200,
    parameter int unsigned RST_LEN         = 4,
    parameter logic [7:0]  FRAMES_PER_STEP = 8'd4,
    parameter logic [15:0] DEB_CYC         = 16'd50000
) (
    input  logic                clk,
    input  logic                rst_n,
    logistic_mu_sweep_if.master bus
);
    typedef enum logic [1:0] {
        S_RESTART,
        S_SETTLE,
        S_HOLD
    } state_t;

    localparam logic [7:0]  RCNT_LAST = 8'(RST_LEN - 1);
    localparam logic [7:0]  FCNT_LAST = FRAMES_PER_STEP - 8'd1;
    localparam logic [15:0] DEB_LAST  = DEB_CYC - 16'd1;

    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       level_q, level_d;
    logic [1:0][15:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]       press;

    state_t      state_q, state_d;
    logic [17:0] mu_q, mu_d;
    logic [8:0]  maxrepeat_q;
    logic [7:0]  rcnt_q, rcnt_d;
    logic [9:0]  scnt_q, scnt_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic        pend_up_q, pend_up_d;
    logic        pend_dn_q, pend_dn_d;
    logic        cycle_rst_n_q, cycle_rst_n_d;
    logic        settled_q, settled_d;

    logic        ev_up, ev_dn, step_up, step_dn;
    logic [18:0] up_sum;
    logic [17:0] up_auto, up_man, down_val;

    // Bit 0 is the up button, bit 1 the down button throughout the debounce path.
    assign btn_raw = {bus.btn_down, bus.btn_up};

    always_comb begin
        level_d   = level_q;
        deb_cnt_d = '0;
        press     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    level_d[i] = sync2_q[i];
                    press[i]   = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Widened by one bit so the wrap/saturate decision never sees an overflowed sum.
    always_comb begin
        up_sum   = {1'b0, mu_q} + {1'b0, MU_STEP};
        up_auto  = (up_sum > {1'b0, MU_MAX}) ? MU_MIN : up_sum[17:0];
        up_man   = (up_sum > {1'b0, MU_MAX}) ? MU_MAX : up_sum[17:0];
        down_val = ({1'b0, mu_q} < ({1'b0, MU_MIN} + {1'b0, MU_STEP})) ? MU_MIN
                                                                        : mu_q - MU_STEP;
    end

    assign ev_up = press[0] & ~press[1];
    assign ev_dn = press[1] & ~press[0];

    always_comb begin
        state_d   = state_q;
        mu_d      = mu_q;
        rcnt_d    = rcnt_q;
        scnt_d    = scnt_q;
        fcnt_d    = fcnt_q;
        pend_up_d = pend_up_q;
        pend_dn_d = pend_dn_q;
        step_up   = 1'b0;
        step_dn   = 1'b0;

        if (bus.auto_en) begin
            pend_up_d = 1'b0;
            pend_dn_d = 1'b0;
        end else if (ev_up) begin
            pend_up_d = 1'b1;
            pend_dn_d = 1'b0;
        end else if (ev_dn) begin
            pend_up_d = 1'b0;
            pend_dn_d = 1'b1;
        end

        case (state_q)
            S_RESTART: begin
                rcnt_d = rcnt_q + 8'd1;
                if (rcnt_q == RCNT_LAST) begin
                    state_d = S_SETTLE;
                    rcnt_d  = 8'd0;
                    scnt_d  = 10'd0;
                end
            end
            S_SETTLE: begin
                scnt_d = scnt_q + 10'd1;
                if (scnt_q == ({1'b0, maxrepeat_q} + 10'd1)) begin
                    state_d = S_HOLD;
                    fcnt_d  = 8'd0;
                end
            end
            S_HOLD: begin
                pend_up_d = 1'b0;
                pend_dn_d = 1'b0;
                if (bus.auto_en) begin
                    if (bus.frame_tick) begin
                        if (fcnt_q == FCNT_LAST) begin
                            mu_d    = up_auto;
                            fcnt_d  = 8'd0;
                            state_d = S_RESTART;
                        end else begin
                            fcnt_d = fcnt_q + 8'd1;
                        end
                    end
                end else begin
                    // A fresh press wins over an older pending one; a cancelled pair leaves pending.
                    fcnt_d  = 8'd0;
                    step_up = ev_up | (~ev_dn & pend_up_q);
                    step_dn = ev_dn | (~ev_up & pend_dn_q);
                    if (step_up) begin
                        mu_d    = up_man;
                        state_d = S_RESTART;
                    end else if (step_dn) begin
                        mu_d    = down_val;
                        state_d = S_RESTART;
                    end
                end
            end
            default: begin
                state_d = S_RESTART;
                rcnt_d  = 8'd0;
            end
        endcase

        cycle_rst_n_d = (state_d != S_RESTART);
        settled_d     = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RESTART;
            mu_q          <= MU_MIN;
            maxrepeat_q   <= REPEAT;
            rcnt_q        <= 8'd0;
            scnt_q        <= 10'd0;
            fcnt_q        <= 8'd0;
            pend_up_q     <= 1'b0;
            pend_dn_q     <= 1'b0;
            cycle_rst_n_q <= 1'b0;
            settled_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            mu_q          <= mu_d;
            maxrepeat_q   <= REPEAT;
            rcnt_q        <= rcnt_d;
            scnt_q        <= scnt_d;
            fcnt_q        <= fcnt_d;
            pend_up_q     <= pend_up_d;
            pend_dn_q     <= pend_dn_d;
            cycle_rst_n_q <= cycle_rst_n_d;
            settled_q     <= settled_d;
        end
    end

    assign bus.mu          = mu_q;
    assign bus.maxrepeat   = maxrepeat_q;
    assign bus.cycle_rst_n = cycle_rst_n_q;
    assign bus.settled     = settled_q;
endmodule

// File: tb/tb_logistic_mu_sweep.sv
// Randomised bench for logistic_mu_sweep; expected outputs come from a timeline model
// (cycles since last mu change, pending press, frame count) stepped once per clock.
module tb_logistic_mu_sweep;
    localparam int MU_MIN   = 32'h2_8000;
    localparam int MU_MAX   = 32'h3_FFF0;
    localparam int MU_STEP  = 32'h0_0400;
    localparam int REPEAT   = 200;
    localparam int RST_LEN  = 4;
    localparam int FPS      = 4;
    localparam int DEB      = 20;
    localparam int HOLD_AGE = RST_LEN + REPEAT + 2;
    localparam logic [31:0] RESET_OUTS = {3'b000, 18'h2_8000, 9'd200, 1'b0, 1'b0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logistic_mu_sweep_if bus ();

    logistic_mu_sweep #(.DEB_CYC(16'd20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int mMu, mAge, mTicks, mPend;
    bit mS1 [2];
    bit mS2 [2];
    bit mLvl[2];
    int mRun[2];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int stepUp(input int mu, input bit wrap);
        int s;
        s = mu + MU_STEP;
        if (s > MU_MAX) return wrap ? MU_MIN : MU_MAX;
        return s;
    endfunction

    function automatic int stepDown(input int mu);
        if (mu - MU_STEP < MU_MIN) return MU_MIN;
        return mu - MU_STEP;
    endfunction

    function automatic logic [31:0] dutOuts();
        return {3'b000, bus.mu, bus.maxrepeat, bus.cycle_rst_n, bus.settled};
    endfunction

    function automatic logic [31:0] modelOuts();
        return {3'b000, 18'(mMu), 9'(REPEAT), (mAge >= RST_LEN), (mAge >= HOLD_AGE)};
    endfunction

    task automatic modelReset();
        mMu    = MU_MIN;
        mAge   = 0;
        mTicks = 0;
        mPend  = 0;
        for (int i = 0; i < 2; i++) begin
            mS1[i] = 0; mS2[i] = 0; mLvl[i] = 0; mRun[i] = 0;
        end
    endtask

    // mPend / dir: 0 = none, 1 = up, 2 = down
    task automatic modelStep(input bit ft, input bit ae, input bit up, input bit dn);
        bit raw[2];
        bit ev[2];
        bit hold;
        int dir;
        raw[0] = up;
        raw[1] = dn;
        for (int i = 0; i < 2; i++) begin
            ev[i] = 0;
            if (mS2[i] != mLvl[i]) begin
                mRun[i]++;
                if (mRun[i] == DEB) begin
                    mLvl[i] = mS2[i];
                    mRun[i] = 0;
                    ev[i]   = mLvl[i];
                end
            end else begin
                mRun[i] = 0;
            end
            mS2[i] = mS1[i];
            mS1[i] = raw[i];
        end
        dir = 0;
        if (ev[0] && !ev[1]) dir = 1;
        else if (ev[1] && !ev[0]) dir = 2;
        hold = (mAge >= HOLD_AGE);
        if (!hold) begin
            mAge++;
            mTicks = 0;
            if (ae) mPend = 0;
            else if (dir != 0) mPend = dir;
        end else if (ae) begin
            mPend = 0;
            if (ft) begin
                mTicks++;
                if (mTicks == FPS) begin
                    mMu    = stepUp(mMu, 1);
                    mAge   = 0;
                    mTicks = 0;
                end
            end
        end else begin
            mTicks = 0;
            if (dir == 0) dir = mPend;
            mPend = 0;
            if (dir == 1) mMu = stepUp(mMu, 0);
            if (dir == 2) mMu = stepDown(mMu);
            if (dir != 0) mAge = 0;
        end
    endtask

    task automatic applyStimulus(input bit ft, input bit ae, input bit up, input bit dn);
        @(negedge clk);
        bus.frame_tick = ft;
        bus.auto_en    = ae;
        bus.btn_up     = up;
        bus.btn_down   = dn;
        @(posedge clk);
        #1;
        modelStep(ft, ae, up, dn);
        checkOutput("outs", dutOuts(), modelOuts());
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        bus.frame_tick = 0; bus.auto_en = 0; bus.btn_up = 0; bus.btn_down = 0;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("reset_outs", dutOuts(), RESET_OUTS);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic waitSettled(input bit ae);
        int n;
        n = 0;
        while (!bus.settled && n < 400) begin
            applyStimulus(0, ae, 0, 0);
            n++;
        end
        checkOutput("settle_wait", 32'(bus.settled), 32'd1);
    endtask

    task automatic pressButton(input bit up, input bit dn, output bit sawRestart);
        sawRestart = 0;
        for (int k = 0; k < DEB + 4; k++) begin
            applyStimulus(0, 0, up, dn);
            if (!bus.cycle_rst_n) sawRestart = 1;
        end
        for (int k = 0; k < DEB + 4; k++) begin
            applyStimulus(0, 0, 0, 0);
            if (!bus.cycle_rst_n) sawRestart = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  riseEdge, settleEdge, holdLen;
        bit  saw, lvl;

        bus.frame_tick = 0; bus.auto_en = 0; bus.btn_up = 0; bus.btn_down = 0;
        modelReset();

        // Reset release: restart low for RST_LEN cycles, then settle window.
        doReset();
        riseEdge   = -1;
        settleEdge = -1;
        for (int e = 1; e <= 400 && settleEdge < 0; e++) begin
            applyStimulus(0, 0, 0, 0);
            if (bus.cycle_rst_n && riseEdge < 0) riseEdge = e;
            if (bus.settled) settleEdge = e;
        end
        checkOutput("rst_low_cycles", 32'(riseEdge), 32'd4);
        checkOutput("settle_latency", 32'(settleEdge - riseEdge), 32'd202);
        checkOutput("mu_initial", 32'(bus.mu), 32'h2_8000);

        // Auto: fourth frame tick steps mu and restarts.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 0, 0);
            if (k == 3) begin
                checkOutput("auto_step_mu", 32'(bus.mu), 32'h2_8400);
                checkOutput("auto_step_flags", {30'd0, bus.cycle_rst_n, bus.settled}, 32'd0);
            end else begin
                applyStimulus(0, 1, 0, 0);
            end
        end
        waitSettled(1);

        // Random auto sweep up to the top grid point, then the wrap.
        for (int n = 0; n < 40000 && !(mMu == 32'h3_FC00 && mAge >= HOLD_AGE); n++)
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0), 0, 0);
        checkOutput("reach_top", 32'(bus.mu), 32'h3_FC00);
        for (int k = 0; k < 4; k++) applyStimulus(1, 1, 0, 0);
        checkOutput("wrap_mu", 32'(bus.mu), 32'h2_8000);
        waitSettled(0);

        // Manual: bouncing up button, then a clean hold, gives exactly one step.
        lvl = 0;
        for (int n = 0; n < 1000; ) begin
            int run;
            run = int'($urandom_range(1, DEB / 2));
            lvl = !lvl;
            for (int k = 0; k < run; k++) applyStimulus(0, 0, lvl, 0);
            n += run;
        end
        for (int k = 0; k < DEB + 5; k++) applyStimulus(0, 0, 1, 0);
        for (int k = 0; k < DEB + 5; k++) applyStimulus(0, 0, 0, 0);
        waitSettled(0);
        checkOutput("one_step_mu", 32'(bus.mu), 32'h2_8400);

        pressButton(0, 1, saw);
        waitSettled(0);
        checkOutput("down_mu", 32'(bus.mu), 32'h2_8000);
        pressButton(0, 1, saw);
        checkOutput("down_sat_restart", 32'(saw), 32'd1);
        waitSettled(0);
        checkOutput("down_sat_mu", 32'(bus.mu), 32'h2_8000);

        // Press during restart/settle is held and applied on the first HOLD cycle.
        pressButton(1, 0, saw);
        pressButton(1, 0, saw);
        waitSettled(0);
        holdLen = 0;
        for (int n = 0; n < 10 && bus.settled; n++) begin
            holdLen++;
            applyStimulus(0, 0, 0, 0);
        end
        checkOutput("pend_hold_len", 32'(holdLen), 32'd1);
        checkOutput("pend_mu", 32'(bus.mu), 32'h2_8800);
        waitSettled(0);

        // Both buttons pressed together cancel.
        pressButton(1, 1, saw);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 0, 0);
            if (!bus.cycle_rst_n) saw = 1;
        end
        checkOutput("both_no_restart", 32'(saw), 32'd0);
        checkOutput("both_mu", 32'(bus.mu), 32'h2_8800);

        // Random mixed segments: buttons, frame ticks and mode changes at any time.
        for (int seg = 0; seg < 200; seg++) begin
            int  dur;
            bit  up, dn, ae;
            dur = int'($urandom_range(1, 60));
            up  = 1'($urandom_range(0, 1));
            dn  = 1'($urandom_range(0, 1));
            ae  = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < dur; k++)
                applyStimulus(1'($urandom_range(0, 1)), ae, up, dn);
        end

        // Async reset in the middle of SETTLE at mu = 3.0.
        doReset();
        for (int n = 0; n < 12000 && mMu != 32'h3_0000; n++) applyStimulus(1, 1, 0, 0);
        for (int k = 0; k < 50; k++) applyStimulus(0, 0, 0, 0);
        checkOutput("pre_rst_mu", 32'(bus.mu), 32'h3_0000);
        checkOutput("pre_rst_flags", {30'd0, bus.cycle_rst_n, bus.settled}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", dutOuts(), RESET_OUTS);
        modelReset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        waitSettled(0);
        checkOutput("post_rst_mu", 32'(bus.mu), 32'h2_8000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
